// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg -- shared pipeline encodings: stall levels, NOP fill, delay-slot flag
// Revision: 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit value replicated across the payload to form the default bubble word.
    localparam logic NOP_BIT = 1'b0;

    localparam logic DS_NONE = 1'b0;
    localparam logic DS_SLOT = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_ADV    = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Flush dominates; otherwise the stage moves unless it is stopped.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic up,
                                                input logic dn);
        if (flush)
            return ACT_FLUSH;
        else if (up == NO_STOP)
            return ACT_ADV;
        else if (dn == NO_STOP)
            return ACT_BUBBLE;
        else
            return ACT_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter -- saturating up-counter with synchronous clear (clear wins)
// Revision: 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != C_MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_stage_reg -- inter-stage pipeline register with stall/bubble/flush
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 112,
    parameter int                STALL_W     = 6,
    parameter int                STAGE       = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL  = {DATA_W{NOP_BIT}},
    parameter bit                ZERO_BUBBLE = 1'b1,
    parameter int                CNT_W       = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               ds_next_i,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               ds_o,
    output logic               adv_o,
    output logic [CNT_W-1:0]   bubble_cnt
);
    generate
        if ((STAGE < 0) || (STAGE >= STALL_W) || (DATA_W < 1)) begin : g_param_err
            $error("pipe_stage_reg: STAGE must be in 0..STALL_W-1 and DATA_W >= 1");
        end
    endgenerate

    logic       w_up;
    logic       w_dn;
    logic       w_stall_unused;
    stage_act_e w_act;

    assign w_up           = stall[STAGE];
    assign w_stall_unused = ^stall;

    // The last stage has no downstream neighbour, so it is never held.
    generate
        if (STAGE == STALL_W - 1) begin : g_dn_last
            assign w_dn = NO_STOP;
        end else begin : g_dn_mid
            assign w_dn = stall[STAGE+1];
        end
    endgenerate

    assign w_act = stage_action(flush, w_up, w_dn);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ds_q,    ds_d;
    logic              adv_q,   adv_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ds_d    = ds_q;
        adv_d   = 1'b0;
        case (w_act)
            ACT_FLUSH: begin
                valid_d = 1'b0;
                data_d  = BUBBLE_VAL;
                ds_d    = DS_NONE;
            end
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                if (ZERO_BUBBLE)
                    data_d = BUBBLE_VAL;
            end
            ACT_ADV: begin
                valid_d = in_valid;
                data_d  = in_data;
                ds_d    = ds_next_i;
                adv_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE_VAL;
            ds_q    <= DS_NONE;
            adv_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ds_q    <= ds_d;
            adv_q   <= adv_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_act == ACT_BUBBLE),
        .clr    (cnt_clr),
        .cnt_o  (bubble_cnt)
    );

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign ds_o      = ds_q;
    assign adv_o     = adv_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg -- directed-vector bench for pipe_stage_reg
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         resetn;
    logic [5:0]   stall;
    logic         flush;
    logic         in_valid;
    logic [111:0] in_data;
    logic         ds_next_i;
    logic         cnt_clr;

    // Instance A: defaults
    logic         a_valid, a_ds, a_adv;
    logic [111:0] a_data;
    logic [15:0]  a_cnt;
    // Instance B: 2-bit counter, payload held on bubble, non-zero bubble word
    logic         b_valid, b_ds, b_adv;
    logic [111:0] b_data;
    logic [1:0]   b_cnt;
    // Instance C: last stage of the stall vector, narrow payload
    logic         c_valid, c_ds, c_adv;
    logic [15:0]  c_data;
    logic [7:0]   c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut_a (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .ds_next_i(ds_next_i),
        .cnt_clr(cnt_clr), .out_valid(a_valid), .out_data(a_data),
        .ds_o(a_ds), .adv_o(a_adv), .bubble_cnt(a_cnt)
    );

    pipe_stage_reg #(
        .BUBBLE_VAL(112'hDEAD), .ZERO_BUBBLE(1'b0), .CNT_W(2)
    ) u_dut_b (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .ds_next_i(ds_next_i),
        .cnt_clr(cnt_clr), .out_valid(b_valid), .out_data(b_data),
        .ds_o(b_ds), .adv_o(b_adv), .bubble_cnt(b_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(16), .STAGE(5), .CNT_W(8)
    ) u_dut_c (
        .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[15:0]), .ds_next_i(ds_next_i),
        .cnt_clr(cnt_clr), .out_valid(c_valid), .out_data(c_data),
        .ds_o(c_ds), .adv_o(c_adv), .bubble_cnt(c_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        stall     = 6'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        ds_next_i = 1'b0;
        cnt_clr   = 1'b0;
        step();
        step();
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_a_data",  a_data,  0);
        check_eq("rst_a_ds",    a_ds,    0);
        check_eq("rst_a_adv",   a_adv,   0);
        check_eq("rst_a_cnt",   a_cnt,   0);
        check_eq("rst_b_data",  b_data,  128'hDEAD);

        // Reset release then advance
        resetn = 1'b1; in_valid = 1'b1; in_data = 112'h1234; ds_next_i = 1'b1;
        step();
        check_eq("adv_a_valid", a_valid, 1);
        check_eq("adv_a_data",  a_data,  128'h1234);
        check_eq("adv_a_adv",   a_adv,   1);
        check_eq("adv_a_ds",    a_ds,    1);
        in_data = 112'h5678;
        step();

        // Bubble x5 at stage 2; stage-5 instance ignores bit 2 and keeps advancing
        stall = 6'b000100;
        step();
        check_eq("bub1_a_adv",   a_adv,   0);
        check_eq("bub1_c_valid", c_valid, 1);
        check_eq("bub1_c_data",  c_data,  128'h5678);
        check_eq("bub1_c_adv",   c_adv,   1);
        step();
        step();
        check_eq("bub3_a_valid", a_valid, 0);
        check_eq("bub3_a_data",  a_data,  0);
        check_eq("bub3_a_cnt",   a_cnt,   3);
        check_eq("bub3_a_ds",    a_ds,    1);
        check_eq("bub3_b_valid", b_valid, 0);
        check_eq("bub3_b_data",  b_data,  128'h5678);
        check_eq("bub3_b_cnt",   b_cnt,   3);
        step();
        step();
        check_eq("bub5_a_cnt", a_cnt, 5);
        check_eq("bub5_b_sat", b_cnt, 3);

        // Advance ABCD, then hold
        stall = 6'b000000; in_data = 112'hABCD; ds_next_i = 1'b0;
        step();
        check_eq("adv2_a_valid", a_valid, 1);
        check_eq("adv2_a_data",  a_data,  128'hABCD);
        check_eq("adv2_a_ds",    a_ds,    0);
        stall = 6'b001100; in_data = 112'h9999;
        step();
        step();
        check_eq("hold_a_data",  a_data,  128'hABCD);
        check_eq("hold_a_valid", a_valid, 1);
        check_eq("hold_a_adv",   a_adv,   0);
        check_eq("hold_a_cnt",   a_cnt,   5);

        // Unrelated stall bits set; stage 2 free, stage 5 bubbles
        stall = 6'b111011; in_data = 112'h1111;
        step();
        check_eq("oth_a_valid", a_valid, 1);
        check_eq("oth_a_data",  a_data,  128'h1111);
        check_eq("oth_a_adv",   a_adv,   1);
        check_eq("oth_a_cnt",   a_cnt,   5);
        check_eq("last_c_valid", c_valid, 0);
        check_eq("last_c_data",  c_data,  0);
        check_eq("last_c_adv",   c_adv,   0);
        check_eq("last_c_cnt",   c_cnt,   1);

        // Flush beats bubble
        flush = 1'b1; stall = 6'b000100; ds_next_i = 1'b1;
        step();
        check_eq("fl_a_valid", a_valid, 0);
        check_eq("fl_a_ds",    a_ds,    0);
        check_eq("fl_a_data",  a_data,  0);
        check_eq("fl_a_cnt",   a_cnt,   5);
        check_eq("fl_a_adv",   a_adv,   0);
        check_eq("fl_b_data",  b_data,  128'hDEAD);
        check_eq("fl_b_cnt",   b_cnt,   3);

        // Clear during bubble leaves counter at zero
        flush = 1'b0; cnt_clr = 1'b1;
        step();
        check_eq("clr_a_cnt", a_cnt, 0);
        check_eq("clr_b_cnt", b_cnt, 0);
        cnt_clr = 1'b0;
        step();
        check_eq("inc_a_cnt", a_cnt, 1);

        // Async reset mid-hold
        stall = 6'b000000; in_data = 112'h7777;
        step();
        check_eq("adv3_a_data", a_data, 128'h7777);
        stall = 6'b001100;
        step();
        #3 resetn = 1'b0;
        #1;
        check_eq("arst_a_valid", a_valid, 0);
        check_eq("arst_a_data",  a_data,  0);
        check_eq("arst_a_ds",    a_ds,    0);
        check_eq("arst_a_cnt",   a_cnt,   0);
        check_eq("arst_b_data",  b_data,  128'hDEAD);
        step();
        resetn = 1'b1;
        step();
        check_eq("post_a_valid", a_valid, 0);
        check_eq("post_a_data",  a_data,  0);
        check_eq("post_a_adv",   a_adv,   0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 112, meaning width of the payload carried between stages.
REQ-002 SHALL have parameter STALL_W, default 6, meaning width of the pipeline stall vector.
REQ-003 SHALL have parameter STAGE, default 2, meaning the upstream stage index in the stall vector; legal range 0..STALL_W-1.
REQ-004 SHALL have parameter BUBBLE_VAL, default all-zero DATA_W, meaning the payload loaded on bubble or flush.
REQ-005 SHALL have parameter ZERO_BUBBLE, default 1, meaning 1 = payload forced to BUBBLE_VAL on bubble, 0 = payload held and only valid cleared.
REQ-006 SHALL have parameter CNT_W, default 16, meaning width of the bubble counter.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 stall  in  STALL_W  per-stage stall vector; bit value 1 = Stop.
REQ-010 flush  in  1  synchronous squash of the stage contents.
REQ-011 in_valid  in  1  upstream slot holds a real instruction.
REQ-012 in_data  in  DATA_W  upstream payload.
REQ-013 ds_next_i  in  1  next instruction is in a delay slot.
REQ-014 cnt_clr  in  1  synchronous clear of the bubble counter.
REQ-015 out_valid  out  1  registered valid.
REQ-016 out_data  out  DATA_W  registered payload.
REQ-017 ds_o  out  1  registered delay-slot flag, returned to decode.
REQ-018 adv_o  out  1  one-cycle pulse, high in the cycle after the stage captured upstream.
REQ-019 bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Function
REQ-020 up SHALL equal stall[STAGE]; dn SHALL equal stall[STAGE+1], or 0 when STAGE = STALL_W-1.
REQ-021 Priority per edge SHALL be: flush > bubble (up=1, dn=0) > advance (up=0) > hold (up=1, dn=1).
REQ-022 Flush SHALL load out_valid=0, out_data=BUBBLE_VAL and ds_o=0 regardless of ZERO_BUBBLE, assert adv_o=0, and not increment bubble_cnt.
REQ-023 Bubble SHALL load out_valid=0 and out_data=BUBBLE_VAL (ZERO_BUBBLE=1) or retain out_data (ZERO_BUBBLE=0), retain ds_o, and increment bubble_cnt.
REQ-024 Advance SHALL load out_valid<=in_valid, out_data<=in_data and ds_o<=ds_next_i, and raise adv_o for the following cycle.
REQ-025 Hold SHALL retain out_valid, out_data and ds_o, and set adv_o=0.
REQ-026 Latency SHALL be exactly one clock from capture to output; there is no combinational input-to-output path.
REQ-027 bubble_cnt SHALL saturate at 2^CNT_W-1 with no wrap; cnt_clr SHALL force 0, and a simultaneous bubble SHALL still leave the counter at 0.
REQ-028 adv_o SHALL be 0 in every cycle not immediately following an advance.
REQ-029 Any stall bit other than STAGE and STAGE+1 SHALL have no effect.

Reset
REQ-030 resetn=0 SHALL asynchronously force out_valid=0, out_data=BUBBLE_VAL, ds_o=0, adv_o=0 and bubble_cnt=0.
REQ-031 Reset asserted mid-hold or mid-bubble SHALL discard the stage contents; the first edge after deassertion SHALL follow REQ-021.

Structure
REQ-032 The Stop/NoStop encodings, the NOP payload constant and the delay-slot flag encodings SHALL reside in the shared package pipe_pkg.
REQ-033 The saturating counter SHALL be a separate sub-module, sat_counter, parametrised by CNT_W with inc and clr inputs.
REQ-034 Elaboration SHALL fail if STAGE >= STALL_W or if DATA_W < 1.

Verification
REQ-035 Reset then advance: resetn 0->1, stall=0, in_valid=1, in_data=0x1234 -> the next edge gives out_valid=1, out_data=0x1234, and adv_o=1 for one cycle.
REQ-036 Bubble: stall=6'b000100 for 3 cycles, ZERO_BUBBLE=1 -> out_valid=0, out_data=0, bubble_cnt=3, ds_o unchanged.
REQ-037 Hold: stall=6'b001100, output previously 0xABCD valid -> out_data=0xABCD and out_valid=1 retained, adv_o=0, bubble_cnt unchanged.
REQ-038 Flush vs bubble: flush=1 with stall=6'b000100 -> out_valid=0, ds_o=0, bubble_cnt unchanged.
REQ-039 Saturation and clear: CNT_W=2 with 5 bubble cycles -> bubble_cnt=3; cnt_clr=1 during a bubble -> bubble_cnt=0.
REQ-040 Async reset mid-hold: resetn=0 between clock edges -> outputs go to reset values before the next edge.
